// File: rtl/cla_pg_source.sv
// cla_pg_source: operand front end for the CLA datapath.
// Takes A/B operands and an add/sub select over valid/ready, then stores the
// per-bit propagate/generate vectors and carry-in in a 2-entry skid buffer
// (output reg + skid reg). Only computed p/g/carry are stored, never a/b.
// Optional feature macro: CLA_GROUP_PG_EN adds registered group P/G outputs
// (grp_p, grp_g). When it is undefined those ports and registers are absent.
module cla_pg_source #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] g,
  output logic             carry_in
`ifdef CLA_GROUP_PG_EN
  ,
  output logic             grp_p,
  output logic             grp_g
`endif
);

  // One stored beat: everything the carry-logic cells need, nothing else.
  typedef struct packed {
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic             c;
`ifdef CLA_GROUP_PG_EN
    logic             gp;
    logic             gg;
`endif
  } beat_t;

  // State encodes the number of valid entries held.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_or_valid;
  logic             r_sr_valid;
  logic             r_in_ready;
  beat_t            r_or;
  beat_t            r_sr;
  beat_t            w_beat;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_accept;
  logic             w_deliver;
  logic             w_ld_or_in;
  logic             w_ld_or_sr;
  logic             w_ld_sr;
`ifdef CLA_GROUP_PG_EN
  logic             w_gg;
`endif

  assign w_accept  = in_valid & r_in_ready;
  assign w_deliver = r_or_valid & out_ready;

  // Compute the beat payload from the raw operands (b inverted for subtract).
  always_comb begin
    w_beat   = '0;
    w_b_eff  = sub ? ~b : b;
    w_beat.p = a ^ w_b_eff;
    w_beat.g = a & w_b_eff;
    w_beat.c = sub;
`ifdef CLA_GROUP_PG_EN
    w_gg = w_beat.g[0];
    for (int unsigned i = 1; i < WIDTH; i++) begin
      w_gg = w_beat.g[i] | (w_beat.p[i] & w_gg);
    end
    w_beat.gp = &w_beat.p;
    w_beat.gg = w_gg;
`endif
  end

  // Next-state and buffer-steering decode.
  always_comb begin
    w_state_nxt = r_state;
    w_ld_or_in  = 1'b0;
    w_ld_or_sr  = 1'b0;
    w_ld_sr     = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_accept) begin
          w_state_nxt = S_ONE;
          w_ld_or_in  = 1'b1;
        end
      end
      S_ONE: begin
        if (w_accept && !w_deliver) begin
          w_state_nxt = S_FULL;
          w_ld_sr     = 1'b1;
        end else if (w_deliver && !w_accept) begin
          w_state_nxt = S_EMPTY;
        end else if (w_accept && w_deliver) begin
          w_ld_or_in  = 1'b1;
        end
      end
      S_FULL: begin
        if (w_deliver) begin
          w_state_nxt = S_ONE;
          w_ld_or_sr  = r_sr_valid;
        end
      end
      default: begin
        w_state_nxt = S_EMPTY;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Valid flags and in_ready, registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_or_valid <= 1'b0;
      r_sr_valid <= 1'b0;
      r_in_ready <= 1'b1;
    end else begin
      r_or_valid <= (w_state_nxt != S_EMPTY);
      r_sr_valid <= (w_state_nxt == S_FULL);
      r_in_ready <= (w_state_nxt != S_FULL);
    end
  end

  // Payload registers; OR is refilled from the input or from SR.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_or <= '0;
      r_sr <= '0;
    end else begin
      if (w_ld_or_in) begin
        r_or <= w_beat;
      end else if (w_ld_or_sr) begin
        r_or <= r_sr;
      end
      if (w_ld_sr) begin
        r_sr <= w_beat;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_or_valid;
  assign p         = r_or.p;
  assign g         = r_or.g;
  assign carry_in  = r_or.c;
`ifdef CLA_GROUP_PG_EN
  assign grp_p     = r_or.gp;
  assign grp_g     = r_or.gg;
`endif

endmodule
